// File: rtl/cpu_run_ctrl_if.sv
// Program-loader stream into the run controller: one 32-bit word per accepted
// valid/ready beat, with ld_last qualifying the final word.
interface cpu_run_ctrl_if;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;

  modport master (output ld_valid, ld_data, ld_last, input ld_ready);
  modport slave  (input ld_valid, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/load sequencer for the single-cycle core: streams a program into IMEM with
// the core held in reset, then free-runs or single-steps it through cpu_en.
module cpu_run_ctrl #(
  parameter int          IMEM_AW    = 8,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter int          CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  cpu_run_ctrl_if.slave      ld,
  input  logic               run_start,
  input  logic               step_req,
  input  logic               halt_req,
  input  logic [31:0]        instr,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_rst_n,
  output logic               cpu_en,
  output logic [2:0]         state,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    STEP = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t             cur;
  logic [IMEM_AW-1:0] ptr;
  logic               is_halt;
  logic               accept;

  assign is_halt     = (instr == HALT_INSTR);
  assign ld.ld_ready = (cur == LOAD);
  assign accept      = rst_n & ld.ld_valid & (cur == LOAD);

  assign imem_we    = accept;
  assign imem_addr  = ptr;
  assign imem_wdata = ld.ld_data;
  assign state      = cur;

  // The halt word is gated off in the very cycle it is fetched, so it never executes.
  assign cpu_en = rst_n & (((cur == RUN) & ~is_halt & ~halt_req) |
                           ((cur == STEP) & ~is_halt));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur       <= IDLE;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      retired   <= '0;
      ptr       <= '0;
    end else begin
      if (cpu_en && (retired != '1))
        retired <= retired + CNT_W'(1);

      if (load_start) begin
        cur       <= LOAD;
        ptr       <= '0;
        err       <= 1'b0;
        done      <= 1'b0;
        retired   <= '0;
        cpu_rst_n <= 1'b0;
      end else begin
        case (cur)
          IDLE: begin
            if (run_start) begin
              cur       <= RUN;
              cpu_rst_n <= 1'b1;
              retired   <= '0;
            end else if (step_req) begin
              cur       <= STEP;
              cpu_rst_n <= 1'b1;
              retired   <= '0;
            end
          end
          LOAD: begin
            if (accept) begin
              ptr <= ptr + IMEM_AW'(1);
              if (ld.ld_last) begin
                cur <= IDLE;
              end else if (&ptr) begin
                // Last IMEM slot filled without ld_last: the program does not fit.
                err <= 1'b1;
                cur <= IDLE;
              end
            end
          end
          RUN: begin
            if (is_halt) begin
              cur  <= HALT;
              done <= 1'b1;
            end else if (halt_req) begin
              cur <= HALT;
            end
          end
          STEP: begin
            cur <= HALT;
            if (is_halt)
              done <= 1'b1;
          end
          HALT: begin
            if (!done) begin
              if (run_start)
                cur <= RUN;
              else if (step_req)
                cur <= STEP;
            end
          end
          default: begin
            cur       <= IDLE;
            cpu_rst_n <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: small IMEM/counter widths, a behavioural core/IMEM
// model feeding instr back, and a queue of expected per-cycle outputs.
module tb_cpu_run_ctrl;

  localparam int          AW = 2;
  localparam int          CW = 3;
  localparam logic [31:0] WH = 32'hFFFF_FFFF;
  localparam logic [31:0] W0 = 32'h2008_0005;
  localparam logic [31:0] W1 = 32'h2108_0001;
  localparam logic [2:0]  I  = 3'd0, L = 3'd1, R = 3'd2, S = 3'd3, H = 3'd4;

  typedef struct {
    string       nm;
    logic        rst_n, load_start, run_start, step_req, halt_req, ld_valid, ld_last;
    logic [31:0] ld_data;
    logic        rdy, we;
    logic [1:0]  addr;
    logic        crst, en;
    logic [2:0]  st;
    logic        dn, er;
    logic [2:0]  rt;
  } vec_t;

  logic          clk;
  logic          rst_n, load_start, run_start, step_req, halt_req;
  logic [31:0]   instr;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst_n, cpu_en, done, err;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  cpu_run_ctrl_if ld_if ();

  cpu_run_ctrl #(.IMEM_AW(AW), .HALT_INSTR(WH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .ld(ld_if),
    .run_start(run_start), .step_req(step_req), .halt_req(halt_req),
    .instr(instr), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n), .cpu_en(cpu_en),
    .state(state), .done(done), .err(err), .retired(retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the core and its instruction memory: PC advances only on cpu_en.
  logic [31:0]   mem [4];
  logic [AW-1:0] pc;
  assign instr = mem[pc];
  always @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
    if (!cpu_rst_n) pc <= '0;
    else if (cpu_en) pc <= pc + 2'd1;
  end

  vec_t exp_q[$];
  vec_t tbl[$];
  int   applied = 0;
  int   miscompares = 0;

  function automatic vec_t mk(string nm, logic r, logic ls, logic rs, logic sr, logic hr,
                              logic lv, logic ll, logic [31:0] d, logic rdy, logic we,
                              logic [1:0] a, logic cr, logic en, logic [2:0] st,
                              logic dn, logic er, logic [2:0] rt);
    vec_t v;
    v.nm = nm; v.rst_n = r; v.load_start = ls; v.run_start = rs; v.step_req = sr;
    v.halt_req = hr; v.ld_valid = lv; v.ld_last = ll; v.ld_data = d;
    v.rdy = rdy; v.we = we; v.addr = a; v.crst = cr; v.en = en; v.st = st;
    v.dn = dn; v.er = er; v.rt = rt;
    return v;
  endfunction

  task automatic check_output();
    vec_t e;
    logic [13:0] act, req;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard: actual=empty queue required=pending vector");
      return;
    end
    e = exp_q.pop_front();
    applied++;
    act = {ld_if.ld_ready, imem_we, imem_addr, cpu_rst_n, cpu_en, state, done, err, retired};
    req = {e.rdy, e.we, e.addr, e.crst, e.en, e.st, e.dn, e.er, e.rt};
    if (act !== req || imem_wdata !== e.ld_data) begin
      miscompares++;
      $display("[TB] FAIL %s #%0d: actual rdy/we/addr/crst/en/st/dn/er/rt=%b wdata=%h, required=%b wdata=%h",
               e.nm, applied, act, imem_wdata, req, e.ld_data);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    rst_n = v.rst_n; load_start = v.load_start; run_start = v.run_start;
    step_req = v.step_req; halt_req = v.halt_req;
    ld_if.ld_valid = v.ld_valid; ld_if.ld_last = v.ld_last; ld_if.ld_data = v.ld_data;
    exp_q.push_back(v);
    #4;
    check_output();
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; run_start = 1'b0; step_req = 1'b0; halt_req = 1'b0;
    ld_if.ld_valid = 1'b0; ld_if.ld_last = 1'b0; ld_if.ld_data = '0;
    repeat (2) @(negedge clk);

    //                rst ls rs sr hr lv ll data   rdy we a cr en st dn er rt
    tbl.push_back(mk("reset",    0,0,0,0,0,1,0,W0,  0,0,0,0,0,I,0,0,0));
    tbl.push_back(mk("load",     1,1,0,0,0,0,0,0,   0,0,0,0,0,I,0,0,0));
    tbl.push_back(mk("load",     1,0,0,0,0,1,0,W0,  1,1,0,0,0,L,0,0,0));
    tbl.push_back(mk("load",     1,0,0,0,0,1,0,W1,  1,1,1,0,0,L,0,0,0));
    tbl.push_back(mk("load",     1,0,0,0,0,1,0,W1,  1,1,2,0,0,L,0,0,0));
    tbl.push_back(mk("load",     1,0,0,0,0,1,1,WH,  1,1,3,0,0,L,0,0,0));
    tbl.push_back(mk("ld_idle",  1,0,0,0,0,1,0,W0,  0,0,0,0,0,I,0,0,0));
    tbl.push_back(mk("run",      1,0,1,0,0,0,0,0,   0,0,0,0,0,I,0,0,0));
    tbl.push_back(mk("run",      1,0,0,0,0,0,0,0,   0,0,0,1,1,R,0,0,0));
    tbl.push_back(mk("run",      1,0,0,0,0,0,0,0,   0,0,0,1,1,R,0,0,1));
    tbl.push_back(mk("run",      1,0,0,0,0,0,0,0,   0,0,0,1,1,R,0,0,2));
    tbl.push_back(mk("run_hword",1,0,0,0,0,0,0,0,   0,0,0,1,0,R,0,0,3));
    tbl.push_back(mk("done_run", 1,0,1,0,0,0,0,0,   0,0,0,1,0,H,1,0,3));
    tbl.push_back(mk("done_step",1,0,0,1,0,0,0,0,   0,0,0,1,0,H,1,0,3));
    tbl.push_back(mk("done_hold",1,0,0,0,0,0,0,0,   0,0,0,1,0,H,1,0,3));
    tbl.push_back(mk("reload",   1,1,0,0,0,0,0,0,   0,0,0,1,0,H,1,0,3));
    tbl.push_back(mk("reload",   1,0,0,0,0,1,0,W0,  1,1,0,0,0,L,0,0,0));
    tbl.push_back(mk("reload",   1,0,0,0,0,1,0,W1,  1,1,1,0,0,L,0,0,0));
    tbl.push_back(mk("reload",   1,0,0,0,0,1,0,W1,  1,1,2,0,0,L,0,0,0));
    tbl.push_back(mk("reload",   1,0,0,0,0,1,1,WH,  1,1,3,0,0,L,0,0,0));
    tbl.push_back(mk("idle",     1,0,0,0,0,0,0,0,   0,0,0,0,0,I,0,0,0));
    tbl.push_back(mk("step",     1,0,0,1,0,0,0,0,   0,0,0,0,0,I,0,0,0));
    tbl.push_back(mk("step",     1,0,0,0,0,0,0,0,   0,0,0,1,1,S,0,0,0));
    tbl.push_back(mk("step",     1,0,0,0,0,0,0,0,   0,0,0,1,0,H,0,0,1));
    tbl.push_back(mk("step",     1,0,0,1,0,0,0,0,   0,0,0,1,0,H,0,0,1));
    tbl.push_back(mk("step",     1,0,0,0,0,0,0,0,   0,0,0,1,1,S,0,0,1));
    tbl.push_back(mk("step",     1,0,0,0,0,0,0,0,   0,0,0,1,0,H,0,0,2));
    tbl.push_back(mk("step",     1,0,0,1,0,0,0,0,   0,0,0,1,0,H,0,0,2));
    tbl.push_back(mk("step",     1,0,0,0,0,0,0,0,   0,0,0,1,1,S,0,0,2));
    tbl.push_back(mk("step",     1,0,0,0,0,0,0,0,   0,0,0,1,0,H,0,0,3));
    tbl.push_back(mk("step",     1,0,0,1,0,0,0,0,   0,0,0,1,0,H,0,0,3));
    tbl.push_back(mk("step_hw",  1,0,0,0,0,0,0,0,   0,0,0,1,0,S,0,0,3));
    tbl.push_back(mk("step_hw",  1,0,0,0,0,0,0,0,   0,0,0,1,0,H,1,0,3));

    for (int i = 0; i < tbl.size(); i++)
      apply_stimulus(tbl[i]);

    // Overflow: four words without ld_last fill IMEM and flag err.
    apply_stimulus(mk("ovf",      1,1,0,0,0,0,0,0,            0,0,0,1,0,H,1,0,3));
    apply_stimulus(mk("ovf",      1,0,0,0,0,1,0,32'hA0,       1,1,0,0,0,L,0,0,0));
    apply_stimulus(mk("ovf",      1,0,0,0,0,1,0,32'hA1,       1,1,1,0,0,L,0,0,0));
    apply_stimulus(mk("ovf",      1,0,0,0,0,1,0,32'hA2,       1,1,2,0,0,L,0,0,0));
    apply_stimulus(mk("ovf",      1,0,0,0,0,1,0,32'hA3,       1,1,3,0,0,L,0,0,0));
    apply_stimulus(mk("ovf_err",  1,0,0,0,0,1,0,32'hA4,       0,0,0,0,0,I,0,1,0));
    apply_stimulus(mk("err_clr",  1,1,0,0,0,0,0,0,            0,0,0,0,0,I,0,1,0));
    apply_stimulus(mk("err_clr",  1,0,0,0,0,0,0,0,            1,0,0,0,0,L,0,0,0));
    apply_stimulus(mk("ld_nohw",  1,0,0,0,0,1,0,32'h1,        1,1,0,0,0,L,0,0,0));
    apply_stimulus(mk("ld_nohw",  1,0,0,0,0,1,0,32'h2,        1,1,1,0,0,L,0,0,0));
    apply_stimulus(mk("ld_nohw",  1,0,0,0,0,1,0,32'h3,        1,1,2,0,0,L,0,0,0));
    apply_stimulus(mk("ld_nohw",  1,0,0,0,0,1,1,32'h4,        1,1,3,0,0,L,0,0,0));

    // halt_req beats run_start in RUN; resume keeps counting and saturates at 7.
    apply_stimulus(mk("hreq",     1,0,1,0,0,0,0,0,            0,0,0,0,0,I,0,0,0));
    apply_stimulus(mk("hreq",     1,0,0,0,0,0,0,0,            0,0,0,1,1,R,0,0,0));
    apply_stimulus(mk("hreq",     1,0,0,0,0,0,0,0,            0,0,0,1,1,R,0,0,1));
    apply_stimulus(mk("hreq_run", 1,0,1,0,1,0,0,0,            0,0,0,1,0,R,0,0,2));
    apply_stimulus(mk("hreq_run", 1,0,0,0,0,0,0,0,            0,0,0,1,0,H,0,0,2));
    apply_stimulus(mk("resume",   1,0,1,0,0,0,0,0,            0,0,0,1,0,H,0,0,2));
    apply_stimulus(mk("resume",   1,0,0,0,0,0,0,0,            0,0,0,1,1,R,0,0,2));
    for (int k = 3; k <= 9; k++)
      apply_stimulus(mk("saturate",1,0,0,0,0,0,0,0,           0,0,0,1,1,R,0,0,(k > 7) ? 3'd7 : 3'(k)));
    apply_stimulus(mk("hreq_lvl", 1,0,0,0,1,0,0,0,            0,0,0,1,0,R,0,0,7));
    apply_stimulus(mk("hreq_lvl", 1,0,0,0,0,0,0,0,            0,0,0,1,0,H,0,0,7));

    // Reset mid-LOAD and mid-RUN kills imem_we/cpu_en in the same cycle.
    apply_stimulus(mk("rst_ld",   1,1,0,0,0,0,0,0,            0,0,0,1,0,H,0,0,7));
    apply_stimulus(mk("rst_ld",   1,0,0,0,0,1,0,32'h1111_1111,1,1,0,0,0,L,0,0,0));
    apply_stimulus(mk("rst_ld",   1,0,0,0,0,1,0,32'h2222_2222,1,1,1,0,0,L,0,0,0));
    apply_stimulus(mk("rst_ld",   0,0,0,0,0,1,0,32'h3333_3333,1,0,2,0,0,L,0,0,0));
    apply_stimulus(mk("rst_ld",   1,0,0,0,0,1,0,32'h4444_4444,0,0,0,0,0,I,0,0,0));
    apply_stimulus(mk("rst_run",  1,0,1,0,0,0,0,0,            0,0,0,0,0,I,0,0,0));
    apply_stimulus(mk("rst_run",  1,0,0,0,0,0,0,0,            0,0,0,1,1,R,0,0,0));
    apply_stimulus(mk("rst_run",  0,0,0,0,0,0,0,0,            0,0,0,1,0,R,0,0,1));
    apply_stimulus(mk("rst_run",  1,0,0,0,0,0,0,0,            0,0,0,0,0,I,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/load sequencer for the single-cycle CPU core (Chip_InstrIP). It streams a program into instruction memory over a valid/ready handshake while holding the core in reset. It then releases the core to free-run or single-step, gating execution with a clock-enable. It stops on a halt request or on fetching a designated halt instruction, and counts retired instructions.

Parameters:
IMEM_AW, 8, instruction-memory word-address width (depth 2^IMEM_AW)
HALT_INSTR, 32'hFFFF_FFFF, opcode word that stops execution without being executed
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
load_start  in  1  one-cycle pulse: begin program load
ld_valid  in  1  loader word valid
ld_data  in  32  loader instruction word
ld_last  in  1  qualifies final word of the load
ld_ready  out  1  controller accepts a word this cycle
run_start  in  1  pulse: free-run from IDLE/HALT
step_req  in  1  pulse: execute one instruction
halt_req  in  1  stop execution (level or pulse)
instr  in  32  instruction currently fetched by the core
imem_we  out  1  instruction-memory write strobe
imem_addr  out  IMEM_AW  instruction-memory write word address
imem_wdata  out  32  instruction-memory write data
cpu_rst_n  out  1  core reset, active-low, registered
cpu_en  out  1  core state-update enable (PC, regfile, data memory)
state  out  3  IDLE=0 LOAD=1 RUN=2 STEP=3 HALT=4
done  out  1  sticky: stopped on HALT_INSTR
err  out  1  sticky: load overflowed IMEM
retired  out  CNT_W  instructions executed since last clear

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; ld_ready=0; cpu_rst_n=0; done=0; err=0; retired=0; imem_addr=0.
- While rst_n=0, combinational outputs imem_we and cpu_en are forced to 0 in the same cycle, including reset asserted mid-LOAD or mid-RUN.
- Command priority, same cycle: load_start > halt_req > run_start > step_req.
- IDLE: cpu_rst_n=0, cpu_en=0.
  - load_start -> LOAD.
  - run_start -> RUN.
  - step_req -> STEP.
  - run_start or step_req from IDLE clears retired.
- LOAD entry: write pointer=0, err=0, done=0, retired=0, cpu_rst_n=0.
  - ld_ready=1 for every cycle in LOAD.
  - Accept = ld_valid & ld_ready. imem_we = accept (combinational), imem_addr = pointer, imem_wdata = ld_data. Pointer increments after each accept.
  - Accept with ld_last=1 -> IDLE next cycle.
  - Accept at pointer = 2^IMEM_AW-1 with ld_last=0: the word is written, err=1, -> IDLE. The pointer wraps to 0 but is not used.
  - load_start inside LOAD restarts the load (pointer=0).
- RUN: cpu_rst_n=1.
  - cpu_en = ~(instr==HALT_INSTR) & ~halt_req (combinational).
  - retired increments in every cycle with cpu_en=1 and saturates at all-ones.
  - instr==HALT_INSTR -> HALT with done=1.
  - halt_req -> HALT; done is unchanged unless instr==HALT_INSTR in the same cycle.
- STEP: lasts exactly one cycle.
  - cpu_rst_n=1 (from IDLE this releases the core at PC=0 first).
  - cpu_en=1 unless instr==HALT_INSTR, in which case done=1.
  - Always -> HALT next cycle.
- HALT: cpu_rst_n=1, cpu_en=0; core state is preserved.
  - run_start -> RUN, or step_req -> STEP, only if done=0. If done=1 both are ignored.
  - load_start -> LOAD.
- Latency:
  - load_start to first possible accept: 1 cycle.
  - run_start to first cpu_en=1: 1 cycle.
  - HALT_INSTR fetch to cpu_en=0: 0 cycles.
- Boundaries:
  - ld_valid outside LOAD is ignored (ld_ready=0).
  - halt_req in IDLE/LOAD/HALT has no effect.

Test Plan:
- Load 4 words 0x20080005, 0x21080001, 0x21080001, 0xFFFFFFFF (last on 4th), ld_valid held high -> imem_we high for 4 consecutive cycles, addr 0..3, state LOAD->IDLE, err=0.
- After that load, pulse run_start -> cpu_rst_n=1, cpu_en high 3 cycles, retired=3. Halt word fetched -> cpu_en=0 the same cycle, state=HALT, done=1; a further run_start is ignored.
- Same program, step_req three times from IDLE, separated by idle cycles -> each step gives one cpu_en pulse, state returns to HALT, retired increments 1,2,3. A fourth step_req sets done=1 with no cpu_en pulse.
- IMEM_AW=2, load 5 words with ld_last never set -> 4 writes (addr 0..3), err=1, state=IDLE. A new load_start clears err.
- In RUN, assert halt_req and run_start in the same cycle -> cpu_en=0 that cycle, state=HALT, done=0. A later run_start resumes with retired continuing, not cleared.
- Drop rst_n mid-LOAD with ld_valid high -> imem_we=0 in that cycle; next cycle state=IDLE, ld_ready=0, cpu_rst_n=0, retired=0.
